vending_ctrl_fsm: RTL and testbench

Parametrised successor to the 4-state vending sequencer. Handles N products with a per-product price table, coin accumulation into a credit register, sold-out rejection, cancel and inactivity timeout with refund, timed dispense, and change return. Sits between the keypad/coin front-end decoders and the dispense/change actuators.

---
 rtl/vending_pkg.sv | 18 +
 rtl/vend_credit_acc.sv | 57 +++++
 rtl/vending_ctrl_fsm.sv | 156 +++++++++++++++
 tb/tb_vending_ctrl_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: FSM state encoding and default bus widths,
// also consumed by the keypad/coin front-end decoders.
package vending_pkg;

  localparam int unsigned DEF_NUM_PRODUCTS = 8;
  localparam int unsigned DEF_ID_W         = $clog2(DEF_NUM_PRODUCTS);
  localparam int unsigned DEF_CREDIT_W     = 8;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SELECTED = 3'd1,
    ST_PAYMENT  = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } vend_state_e;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit accumulator with saturating coin add, plus the payment inactivity
// counter; both are cleared/loaded under FSM control.
module vend_credit_acc
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W    = DEF_CREDIT_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_value,
  input  logic                cnt_en,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] sat_sum_c,
  output logic                cnt_last_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CREDIT_W:0]   sum_c;

  // Counter holds at its last value so it can never wrap back into range.
  always_comb begin
    sum_c     = {1'b0, credit_q} + {1'b0, add_value};
    sat_sum_c = sum_c[CREDIT_W] ? '1 : sum_c[CREDIT_W-1:0];
    credit_d  = credit_q;
    cnt_d     = cnt_q;
    if (clr) begin
      credit_d = '0;
      cnt_d    = '0;
    end else if (add_en) begin
      credit_d = sat_sum_c;
      cnt_d    = '0;
    end else if (cnt_en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= '0;
      cnt_q    <= '0;
    end else begin
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign credit     = credit_q;
  assign cnt_last_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/vending_ctrl_fsm.sv
// Multi-product vending sequencer: selection, coin payment with cancel and
// inactivity refund, timed dispense and change return.
module vending_ctrl_fsm
  import vending_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = DEF_NUM_PRODUCTS,
  parameter int unsigned ID_W         = $clog2(NUM_PRODUCTS),
  parameter int unsigned CREDIT_W     = DEF_CREDIT_W,
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned DISPENSE_CYC = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sel_valid,
  input  logic [ID_W-1:0]                  sel_id,
  input  logic                             coin_valid,
  input  logic [CREDIT_W-1:0]              coin_value,
  input  logic                             cancel,
  input  logic [NUM_PRODUCTS*CREDIT_W-1:0] price_flat,
  input  logic [NUM_PRODUCTS-1:0]          stock_empty,
  output logic [STATE_W-1:0]               state,
  output logic [CREDIT_W-1:0]              credit,
  output logic                             dispense_valid,
  output logic [ID_W-1:0]                  dispense_id,
  output logic                             change_valid,
  output logic [CREDIT_W-1:0]              change_amount,
  output logic                             sel_err
);

  localparam int unsigned DCNT_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DISPENSE_CYC - 1);

  vend_state_e         state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [DCNT_W-1:0]   disp_cnt_q, disp_cnt_d;
  logic                dispense_valid_q, dispense_valid_d;
  logic [ID_W-1:0]     dispense_id_q, dispense_id_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                sel_err_q, sel_err_d;

  logic [CREDIT_W-1:0] sel_price_c, amount_c, credit_c, sat_sum_c;
  logic                sel_ok_c, acc_clr_c, acc_add_c, acc_cnt_c, cnt_last_c;

  assign acc_clr_c = !(state_q inside {ST_IDLE, ST_PAYMENT, ST_DISPENSE});
  assign acc_add_c = (state_q == ST_PAYMENT) && coin_valid;
  assign acc_cnt_c = (state_q == ST_PAYMENT);

  vend_credit_acc #(
    .CREDIT_W    (CREDIT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clr        (acc_clr_c),
    .add_en     (acc_add_c),
    .add_value  (coin_value),
    .cnt_en     (acc_cnt_c),
    .credit     (credit_c),
    .sat_sum_c  (sat_sum_c),
    .cnt_last_c (cnt_last_c)
  );

  // Out-of-range ids match no entry, so they read as not-sellable.
  always_comb begin
    sel_price_c = '0;
    sel_ok_c    = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_price_c = price_flat[i*CREDIT_W +: CREDIT_W];
        sel_ok_c    = !stock_empty[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    price_d    = price_q;
    disp_cnt_d = disp_cnt_q;
    sel_err_d  = 1'b0;
    amount_c   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (sel_ok_c) begin
            id_d    = sel_id;
            price_d = sel_price_c;
            state_d = ST_SELECTED;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_SELECTED: state_d = ST_PAYMENT;
      // Purchase check uses registered credit; a same-cycle coin joins any refund.
      ST_PAYMENT: begin
        if (credit_c >= price_q) begin
          state_d    = ST_DISPENSE;
          disp_cnt_d = '0;
        end else if (cancel || (cnt_last_c && !coin_valid)) begin
          state_d  = ST_CHANGE;
          amount_c = coin_valid ? sat_sum_c : credit_c;
        end
      end
      ST_DISPENSE: begin
        if (disp_cnt_q == DCNT_LAST) begin
          state_d  = ST_CHANGE;
          amount_c = credit_c - price_q;
        end else begin
          disp_cnt_d = disp_cnt_q + 1'b1;
        end
      end
      ST_CHANGE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    dispense_valid_d = (state_d == ST_DISPENSE);
    dispense_id_d    = dispense_valid_d ? id_d : '0;
    change_valid_d   = (state_d == ST_CHANGE) && (amount_c != '0);
    change_amount_d  = change_valid_d ? amount_c : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      id_q             <= '0;
      price_q          <= '0;
      disp_cnt_q       <= '0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
      sel_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      id_q             <= id_d;
      price_q          <= price_d;
      disp_cnt_q       <= disp_cnt_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      change_valid_q   <= change_valid_d;
      change_amount_q  <= change_amount_d;
      sel_err_q        <= sel_err_d;
    end
  end

  assign state          = state_q;
  assign credit         = credit_c;
  assign dispense_valid = dispense_valid_q;
  assign dispense_id    = dispense_id_q;
  assign change_valid   = change_valid_q;
  assign change_amount  = change_amount_q;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_vending_ctrl_fsm.sv
// Scoreboard bench for vending_ctrl_fsm: stimulus queues expected events and
// state probes, a negedge monitor pops and compares them.
module tb_vending_ctrl_fsm;

  localparam int unsigned NP  = 6;
  localparam int unsigned IDW = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned TO  = 10;
  localparam int unsigned DC  = 4;

  localparam int EV_ERR  = 0;
  localparam int EV_DISP = 1;
  localparam int EV_CHG  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              sel_valid;
  logic [IDW-1:0]    sel_id;
  logic              coin_valid;
  logic [CW-1:0]     coin_value;
  logic              cancel;
  logic [NP*CW-1:0]  price_flat;
  logic [NP-1:0]     stock_empty;
  logic [2:0]        state;
  logic [CW-1:0]     credit;
  logic              dispense_valid;
  logic [IDW-1:0]    dispense_id;
  logic              change_valid;
  logic [CW-1:0]     change_amount;
  logic              sel_err;

  vending_ctrl_fsm #(
    .NUM_PRODUCTS (NP),
    .ID_W         (IDW),
    .CREDIT_W     (CW),
    .TIMEOUT_CYC  (TO),
    .DISPENSE_CYC (DC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sel_valid      (sel_valid),
    .sel_id         (sel_id),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .cancel         (cancel),
    .price_flat     (price_flat),
    .stock_empty    (stock_empty),
    .state          (state),
    .credit         (credit),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .change_valid   (change_valid),
    .change_amount  (change_amount),
    .sel_err        (sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int at; int val; int len; } ev_t;
  typedef struct { int at; int st; int cr; bit dv; bit cv; } probe_t;

  ev_t    evq[$];
  probe_t pq[$];
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;
  bit     fin = 1'b0;
  int     dlen = 0;
  int     exp_len = -1;
  bit     dprev = 1'b0;
  bit     cprev = 1'b0;

  function automatic void expect_ev(int kind, int at, int val, int len);
    evq.push_back('{kind, at, val, len});
  endfunction

  function automatic void probe(int at, int st, int cr, bit dv, bit cv);
    pq.push_back('{at, st, cr, dv, cv});
  endfunction

  task automatic got(input int kind, input int val);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      exp_len = -1;
      $display("FAIL event: got kind=%0d val=%0d at cyc %0d, expected no event", kind, val, cyc);
    end else begin
      e = evq.pop_front();
      if (kind == EV_DISP) exp_len = e.len;
      if (e.kind != kind || e.at != cyc || e.val != val) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.at);
      end
    end
  endtask

  // Monitor: state probes, output events, dispense length, idle change_amount.
  always @(negedge clk) begin : mon
    probe_t p;
    while (pq.size() > 0 && pq[0].at <= cyc) begin
      p = pq.pop_front();
      checks++;
      if (p.at != cyc || int'(state) != p.st || int'(credit) != p.cr ||
          dispense_valid != p.dv || change_valid != p.cv) begin
        errors++;
        $display("FAIL probe@%0d: state=%0d credit=%0d dv=%0b cv=%0b (cyc %0d), expected state=%0d credit=%0d dv=%0b cv=%0b",
                 p.at, state, credit, dispense_valid, change_valid, cyc, p.st, p.cr, p.dv, p.cv);
      end
    end
    if (sel_err) got(EV_ERR, 0);
    if (dispense_valid && !dprev) begin
      got(EV_DISP, int'(dispense_id));
      dlen = 0;
    end
    if (dispense_valid) dlen++;
    if (!dispense_valid && dprev) begin
      checks++;
      if (dlen != exp_len) begin
        errors++;
        $display("FAIL dispense_len: got %0d cycles, expected %0d", dlen, exp_len);
      end
    end
    if (change_valid) got(EV_CHG, int'(change_amount));
    if (cprev && !change_valid) begin
      checks++;
      if (change_amount != '0) begin
        errors++;
        $display("FAIL change_idle: change_amount=%0d, expected 0", change_amount);
      end
    end
    dprev = dispense_valid;
    cprev = change_valid;
    if (done && !fin) begin
      checks++;
      if (evq.size() != 0 || pq.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d events and %0d probes pending, expected 0 and 0", evq.size(), pq.size());
      end
      fin = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_value = CW'(v);
    step();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  // Returns in the first PAYMENT cycle.
  task automatic select(input int id);
    sel_valid = 1'b1;
    sel_id    = IDW'(id);
    step();
    sel_valid = 1'b0;
    sel_id    = '0;
    step();
  endtask

  task automatic set_price(input int id, input int v);
    price_flat[id*CW +: CW] = CW'(v);
  endtask

  initial begin
    int c;
    reset       = 1'b1;
    sel_valid   = 1'b0;
    sel_id      = '0;
    coin_valid  = 1'b0;
    coin_value  = '0;
    cancel      = 1'b0;
    price_flat  = '0;
    stock_empty = 6'b100000;
    set_price(0, 0);
    set_price(1, 30);
    set_price(2, 50);
    set_price(3, 255);
    set_price(4, 40);
    set_price(5, 20);

    repeat (3) step();
    probe(cyc, 0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // Product 2, coins 20+20+20, price edit after selection must be ignored.
    select(2);
    probe(cyc, 2, 0, 1'b0, 1'b0);
    set_price(2, 5);
    coin(20);
    coin(20);
    c = cyc;
    expect_ev(EV_DISP, c + 2, 2, 4);
    expect_ev(EV_CHG, c + 6, 10, 0);
    probe(c + 2, 3, 60, 1'b1, 1'b0);
    probe(c + 9, 0, 0, 1'b0, 1'b0);
    coin(20);
    repeat (8) step();
    set_price(2, 50);

    // Price 0 dispenses on the first PAYMENT cycle, no change.
    c = cyc;
    expect_ev(EV_DISP, c + 3, 0, 4);
    probe(c + 3, 3, 0, 1'b1, 1'b0);
    probe(c + 10, 0, 0, 1'b0, 1'b0);
    select(0);
    repeat (8) step();

    // Exact payment: CHANGE without pulse, credit back to 0.
    select(1);
    c = cyc;
    expect_ev(EV_DISP, c + 3, 1, 4);
    probe(c + 7, 4, 30, 1'b0, 1'b0);
    probe(c + 8, 0, 0, 1'b0, 1'b0);
    coin(10);
    coin(20);
    repeat (6) step();

    // Sold out, then out-of-range id.
    c = cyc;
    expect_ev(EV_ERR, c + 1, 0, 0);
    probe(c + 1, 0, 0, 1'b0, 1'b0);
    sel_valid = 1'b1;
    sel_id    = 3'd5;
    step();
    sel_valid = 1'b0;
    step();
    c = cyc;
    expect_ev(EV_ERR, c + 1, 0, 0);
    probe(c + 1, 0, 0, 1'b0, 1'b0);
    sel_valid = 1'b1;
    sel_id    = 3'd7;
    step();
    sel_valid = 1'b0;
    step();

    // Cancel with a same-cycle coin refunds 15+5.
    select(4);
    c = cyc;
    expect_ev(EV_CHG, c + 2, 20, 0);
    probe(c + 2, 4, 20, 1'b0, 1'b1);
    probe(c + 4, 0, 0, 1'b0, 1'b0);
    coin(15);
    coin_valid = 1'b1;
    coin_value = 8'd5;
    cancel     = 1'b1;
    step();
    coin_valid = 1'b0;
    coin_value = '0;
    cancel     = 1'b0;
    repeat (3) step();

    // Timeout refund of a single coin.
    select(2);
    c = cyc;
    expect_ev(EV_CHG, c + 11, 7, 0);
    probe(c + 10, 2, 7, 1'b0, 1'b0);
    probe(c + 11, 4, 7, 1'b0, 1'b1);
    probe(c + 14, 0, 0, 1'b0, 1'b0);
    coin(7);
    repeat (13) step();

    // A coin on the last idle cycle restarts the timeout.
    select(2);
    c = cyc;
    expect_ev(EV_CHG, c + 21, 10, 0);
    probe(c + 11, 2, 10, 1'b0, 1'b0);
    probe(c + 23, 0, 0, 1'b0, 1'b0);
    coin(7);
    repeat (9) step();
    coin(3);
    repeat (12) step();

    // Saturating credit: 200+200 clips to 255, buys the 255 product exactly.
    select(3);
    c = cyc;
    expect_ev(EV_DISP, c + 3, 3, 4);
    probe(c + 2, 2, 255, 1'b0, 1'b0);
    probe(c + 3, 3, 255, 1'b1, 1'b0);
    probe(c + 10, 0, 0, 1'b0, 1'b0);
    coin(200);
    coin(200);
    repeat (8) step();

    // Reset during DISPENSE: dispense cut short, credit lost, no change pulse.
    select(2);
    c = cyc;
    expect_ev(EV_DISP, c + 2, 2, 2);
    probe(c + 3, 3, 50, 1'b1, 1'b0);
    probe(c + 4, 0, 0, 1'b0, 1'b0);
    coin(50);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();

    done = 1'b1;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
